// File: rtl/stage3_driver.sv
// Sequential driver for the stage-3 evaluator: accepts player moves, presents them
// with LFSR luck to the evaluator, and keeps round/score/lives bookkeeping per game.
module stage3_driver #(
  parameter int         ROUNDS = 8,
  parameter logic [7:0] SEED   = 8'hA5,
  parameter int         LIVES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [2:0] move_slide,
  input  logic [2:0] move_timing,
  input  logic       pass2_in,
  input  logic [1:0] bonus2_in,
  output logic [2:0] slide,
  output logic [2:0] timing,
  output logic [2:0] luck3,
  output logic [1:0] bonus2,
  output logic       pass2,
  input  logic       pass3,
  output logic [3:0] round_cnt,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       done,
  output logic       win
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_MOVE = 2'd1,
    DRIVE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [7:0] SEED_START = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0] ROUNDS_L   = ROUNDS[3:0];
  localparam logic [1:0] LIVES_L    = LIVES[1:0];

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // A passed move is worth 2 when the slide is large, otherwise 1; clamp at 255.
  function automatic logic [7:0] score_add(input logic [7:0] s, input logic [2:0] sl);
    logic [8:0] sum;
    sum = {1'b0, s} + ((sl > 3'd4) ? 9'd2 : 9'd1);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  state_t     state_r, state_s;
  logic [7:0] lfsr_r, lfsr_s;
  logic [2:0] slide_r, slide_s, timing_r, timing_s;
  logic [1:0] bonus2_r, bonus2_s, lives_r, lives_s;
  logic       pass2_r, pass2_s, done_r, done_s, win_r, win_s;
  logic       move_ready_r, move_ready_s;
  logic [3:0] round_r, round_s;
  logic [7:0] score_r, score_s;

  // Next-state and next-value logic for the game FSM.
  always_comb begin
    state_s  = state_r;
    lfsr_s   = lfsr_r;
    slide_s  = slide_r;
    timing_s = timing_r;
    bonus2_s = bonus2_r;
    pass2_s  = pass2_r;
    lives_s  = lives_r;
    round_s  = round_r;
    score_s  = score_r;
    done_s   = done_r;
    win_s    = win_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          lfsr_s  = SEED_START;
          lives_s = LIVES_L;
          score_s = 8'd0;
          round_s = 4'd0;
          done_s  = 1'b0;
          win_s   = 1'b0;
          state_s = WAIT_MOVE;
        end else begin
          state_s = state_r;
        end
      end
      WAIT_MOVE: begin
        if (move_valid && move_ready_r) begin
          slide_s  = move_slide;
          timing_s = move_timing;
          bonus2_s = bonus2_in;
          pass2_s  = pass2_in;
          state_s  = DRIVE;
        end else begin
          state_s = WAIT_MOVE;
        end
      end
      DRIVE: begin
        round_s = round_r + 4'd1;
        lfsr_s  = lfsr_next(lfsr_r);
        if (pass3) begin
          score_s = score_add(score_r, slide_r);
        end else begin
          lives_s = lives_r - 2'd1;
        end
        // Running out of lives loses even on the final round.
        if (lives_s == 2'd0) begin
          state_s = DONE;
          done_s  = 1'b1;
          win_s   = 1'b0;
        end else if (round_s == ROUNDS_L) begin
          state_s = DONE;
          done_s  = 1'b1;
          win_s   = 1'b1;
        end else begin
          state_s = WAIT_MOVE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    move_ready_s = (state_s == WAIT_MOVE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lfsr_r       <= SEED;
      slide_r      <= 3'd0;
      timing_r     <= 3'd0;
      bonus2_r     <= 2'd0;
      pass2_r      <= 1'b0;
      lives_r      <= 2'd0;
      round_r      <= 4'd0;
      score_r      <= 8'd0;
      done_r       <= 1'b0;
      win_r        <= 1'b0;
      move_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      lfsr_r       <= lfsr_s;
      slide_r      <= slide_s;
      timing_r     <= timing_s;
      bonus2_r     <= bonus2_s;
      pass2_r      <= pass2_s;
      lives_r      <= lives_s;
      round_r      <= round_s;
      score_r      <= score_s;
      done_r       <= done_s;
      win_r        <= win_s;
      move_ready_r <= move_ready_s;
    end
  end

  assign move_ready = move_ready_r;
  assign slide      = slide_r;
  assign timing     = timing_r;
  assign luck3      = lfsr_r[2:0];
  assign bonus2     = bonus2_r;
  assign pass2      = pass2_r;
  assign round_cnt  = round_r;
  assign score      = score_r;
  assign lives      = lives_r;
  assign done       = done_r;
  assign win        = win_r;

endmodule

// File: tb/tb_stage3_driver.sv
// Directed plus randomized bench for stage3_driver with a game-level reference model.
module tb_stage3_driver;

  localparam int         ROUNDS = 3;
  localparam logic [7:0] SEED   = 8'hA5;
  localparam int         LIVES  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, move_valid, move_ready;
  logic [2:0] move_slide, move_timing;
  logic       pass2_in;
  logic [1:0] bonus2_in;
  logic [2:0] slide, timing, luck3;
  logic [1:0] bonus2;
  logic       pass2, pass3;
  logic [3:0] round_cnt;
  logic [7:0] score;
  logic [1:0] lives;
  logic       done, win;

  int n_checks = 0;
  int n_fail   = 0;

  // Game-level reference state
  int         m_score, m_lives, m_round;
  logic [7:0] m_lfsr;
  bit         m_done, m_win;
  int         m_slide, m_timing, m_bonus2, m_pass2;

  stage3_driver #(.ROUNDS(ROUNDS), .SEED(SEED), .LIVES(LIVES)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_slide(move_slide), .move_timing(move_timing),
    .pass2_in(pass2_in), .bonus2_in(bonus2_in),
    .slide(slide), .timing(timing), .luck3(luck3),
    .bonus2(bonus2), .pass2(pass2), .pass3(pass3),
    .round_cnt(round_cnt), .score(score), .lives(lives),
    .done(done), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] r;
    r = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return r;
  endfunction

  task automatic model_reset();
    m_score = 0; m_lives = 0; m_round = 0; m_lfsr = SEED;
    m_done = 1'b0; m_win = 1'b0;
    m_slide = 0; m_timing = 0; m_bonus2 = 0; m_pass2 = 0;
  endtask

  task automatic check_all(input string tag, input bit ready_exp);
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".lives"}, int'(lives), m_lives);
    chk({tag, ".round"}, int'(round_cnt), m_round);
    chk({tag, ".luck3"}, int'(luck3), int'(m_lfsr[2:0]));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".win"}, int'(win), int'(m_win));
    chk({tag, ".ready"}, int'(move_ready), int'(ready_exp));
    chk({tag, ".slide"}, int'(slide), m_slide);
    chk({tag, ".timing"}, int'(timing), m_timing);
    chk({tag, ".bonus2"}, int'(bonus2), m_bonus2);
    chk({tag, ".pass2"}, int'(pass2), m_pass2);
  endtask

  // Called at a negedge; ends at a negedge.
  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_score = 0; m_lives = LIVES; m_round = 0;
    m_lfsr = (SEED == 8'h00) ? 8'h01 : SEED;
    m_done = 1'b0; m_win = 1'b0;
    check_all("start", 1'b1);
  endtask

  // Called at a negedge; presents a move, drives pass3 during DRIVE, checks the result.
  task automatic do_move(input int s, input int t, input int b, input int p2,
                         input bit p3, input bit hold);
    int n;
    move_slide  = 3'(s);
    move_timing = 3'(t);
    bonus2_in   = 2'(b);
    pass2_in    = 1'(p2);
    move_valid  = 1'b1;
    n = 0;
    while (!move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", 0, 1);
      move_valid = 1'b0;
      return;
    end
    @(negedge clk);
    m_slide = s; m_timing = t; m_bonus2 = b; m_pass2 = p2;
    check_all("drive", 1'b0);
    if (!hold) move_valid = 1'b0;
    pass3 = p3;
    @(negedge clk);
    pass3 = 1'b0;
    if (p3) m_score = (m_score + 1 + ((s > 4) ? 1 : 0) > 255) ? 255 : m_score + 1 + ((s > 4) ? 1 : 0);
    else    m_lives = m_lives - 1;
    m_round++;
    m_lfsr = lfsr_step(m_lfsr);
    if (m_lives == 0) begin m_done = 1'b1; m_win = 1'b0; end
    else if (m_round == ROUNDS) begin m_done = 1'b1; m_win = 1'b1; end
    check_all("after", !m_done);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; pass3 = 1'b0;
    move_slide = 3'd0; move_timing = 3'd0; pass2_in = 1'b0; bonus2_in = 2'd0;
    model_reset();
    @(negedge clk);
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle", 1'b0);

    start_game();
    do_move(2, 1, 3, 1, 1'b1, 1'b0);
    chk("lfsr_4a_luck", int'(luck3), 2);
    // start mid-game is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_all("start_ignored", 1'b1);
    // second move held valid through DRIVE, then a third distinct move
    do_move(5, 6, 2, 0, 1'b1, 1'b1);
    do_move(3, 4, 1, 1, 1'b0, 1'b0);
    @(negedge clk);
    check_all("win_hold", 1'b0);

    // three failures: lose takes priority over reaching the last round
    start_game();
    for (int i = 0; i < 3; i++) do_move(i + 1, 7 - i, i, i % 2, 1'b0, 1'b0);
    @(negedge clk);
    check_all("lose_hold", 1'b0);

    // randomized games
    for (int g = 0; g < 6; g++) begin
      start_game();
      while (!m_done) begin
        do_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
        if (n_checks > 5000) break;
      end
    end

    // reset asserted during DRIVE
    start_game();
    move_slide = 3'd6; move_timing = 3'd2; bonus2_in = 2'd1; pass2_in = 1'b1;
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    pass3 = 1'b1;
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_drive", 1'b0);
    @(negedge clk);
    check_all("rst_held", 1'b0);
    pass3 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    start_game();
    do_move(7, 0, 0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
